// File: rtl/spi_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_readback
//  Purpose  : Queues 16-bit SPI words in a 4-deep FIFO and streams each one
//             to a UART transmitter as bytes, high byte first.
//             Define SPI_READBACK_HDR_EN to prefix every word with 0xA5.
//  Revision : 1.0  initial release
// ============================================================================
module spi_readback (
    input  logic        clk_150MHz_i,
    input  logic        reset,
    input  logic        spi_busy,
    input  logic [15:0] spi_rx_data,
    input  logic        tx_uart_busy,
    output logic [7:0]  tx_uart_data,
    output logic        tx_uart_start,
    output logic [2:0]  fifo_level,
    output logic        overflow
);

    localparam logic [3:0] c_ACK_LAST = 4'd15;
    localparam logic [2:0] c_FIFO_DEPTH = 3'd4;
`ifdef SPI_READBACK_HDR_EN
    localparam logic [1:0] c_LAST_IDX = 2'd2;
    localparam logic [7:0] c_HDR_BYTE = 8'hA5;
`else
    localparam logic [1:0] c_LAST_IDX = 2'd1;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_ACK   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_busy_d;
    logic [15:0] r_mem [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_level;
    logic        r_overflow;

    logic [15:0] r_hold;
    logic [1:0]  r_byte_idx;
    logic [3:0]  r_ack_cnt;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;

    logic        w_capture;
    logic        w_full;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic        w_load;
    logic        w_clr_timer;
    logic        w_inc_idx;
    logic [7:0]  w_byte;

    // A full FIFO still accepts a word when the head is popped on the same edge.
    assign w_capture = r_busy_d & ~spi_busy;
    assign w_full    = (r_level == c_FIFO_DEPTH);
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;

    always_ff @(posedge clk_150MHz_i) begin
        if (reset) begin
            r_busy_d   <= 1'b0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_level    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            r_busy_d <= spi_busy;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 3'd1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 3'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_150MHz_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= spi_rx_data;
        end
    end

    always_ff @(posedge clk_150MHz_i) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_clr_timer = 1'b0;
        w_inc_idx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_level != 3'd0) && !tx_uart_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_START;
            end
            S_START: begin
                w_clr_timer = 1'b1;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                // A UART that never reports busy must not hang the stream.
                if (tx_uart_busy || (r_ack_cnt == c_ACK_LAST)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!tx_uart_busy) begin
                    if (r_byte_idx != c_LAST_IDX) begin
                        w_inc_idx   = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
`ifdef SPI_READBACK_HDR_EN
        case (r_byte_idx)
            2'd0:    w_byte = c_HDR_BYTE;
            2'd1:    w_byte = r_hold[15:8];
            default: w_byte = r_hold[7:0];
        endcase
`else
        if (r_byte_idx[0]) begin
            w_byte = r_hold[7:0];
        end else begin
            w_byte = r_hold[15:8];
        end
`endif
    end

    // Start is registered off LOAD so it lines up with the START state cycle.
    always_ff @(posedge clk_150MHz_i) begin
        if (reset) begin
            r_hold     <= 16'h0000;
            r_byte_idx <= 2'd0;
            r_ack_cnt  <= 4'd0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
        end else begin
            if (w_pop) begin
                r_hold     <= r_mem[r_rd_ptr];
                r_byte_idx <= 2'd0;
            end else if (w_inc_idx) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (w_load) begin
                r_tx_data <= w_byte;
            end
            r_tx_start <= w_load;
            if (w_clr_timer) begin
                r_ack_cnt <= 4'd0;
            end else if (r_state == S_ACK) begin
                r_ack_cnt <= r_ack_cnt + 4'd1;
            end
        end
    end

    assign tx_uart_data  = r_tx_data;
    assign tx_uart_start = r_tx_start;
    assign fifo_level    = r_level;
    assign overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_spi_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_readback
//  Purpose  : Scoreboard bench for spi_readback; expected UART bytes are
//             queued at capture time and popped on every start pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_readback;

`ifdef SPI_READBACK_HDR_EN
    localparam int c_BPW = 3;
`else
    localparam int c_BPW = 2;
`endif
    localparam int c_ACK_GAP = 16 + 3;

    logic        clk_150MHz_i = 1'b0;
    logic        reset        = 1'b1;
    logic        spi_busy     = 1'b0;
    logic [15:0] spi_rx_data  = 16'h0000;
    logic        tx_uart_busy = 1'b0;
    logic [7:0]  tx_uart_data;
    logic        tx_uart_start;
    logic [2:0]  fifo_level;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    int          n_starts = 0;
    int          cyc = 0;
    int          uart_mode = 0;   // 0 responsive, 1 held busy, 2 never busy
    int          busy_cnt = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  sb[$];

    spi_readback dut (
        .clk_150MHz_i (clk_150MHz_i),
        .reset        (reset),
        .spi_busy     (spi_busy),
        .spi_rx_data  (spi_rx_data),
        .tx_uart_busy (tx_uart_busy),
        .tx_uart_data (tx_uart_data),
        .tx_uart_start(tx_uart_start),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    always #5 clk_150MHz_i = ~clk_150MHz_i;

    always @(posedge clk_150MHz_i) cyc <= cyc + 1;

    // UART model: a start pulse makes it busy for five cycles.
    always @(negedge clk_150MHz_i) begin
        case (uart_mode)
            1: tx_uart_busy = 1'b1;
            2: tx_uart_busy = 1'b0;
            default: begin
                if (tx_uart_start) busy_cnt = 5;
                if (busy_cnt > 0) begin
                    tx_uart_busy = 1'b1;
                    busy_cnt = busy_cnt - 1;
                end else begin
                    tx_uart_busy = 1'b0;
                end
            end
        endcase
    end

    always @(negedge clk_150MHz_i) begin
        logic [7:0] exp_b;
        if (tx_uart_start) begin
            n_starts = n_starts + 1;
            checks = checks + 1;
            if (prev_start) begin
                errors = errors + 1;
                $display("FAIL start_consecutive got two starts in a row expected single-cycle pulse");
            end
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected_byte got %02h expected no start", tx_uart_data);
            end else begin
                exp_b = sb.pop_front();
                if (tx_uart_data !== exp_b) begin
                    errors = errors + 1;
                    $display("FAIL sb_byte got %02h expected %02h", tx_uart_data, exp_b);
                end
            end
        end
        prev_start = tx_uart_start;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [15:0] w);
`ifdef SPI_READBACK_HDR_EN
        sb.push_back(8'hA5);
`endif
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
    endtask

    task automatic capture(input logic [15:0] w, input bit accept);
        @(negedge clk_150MHz_i);
        spi_busy = 1'b1;
        spi_rx_data = w;
        @(negedge clk_150MHz_i);
        spi_busy = 1'b0;
        if (accept) push_word(w);
    endtask

    task automatic apply_reset();
        @(negedge clk_150MHz_i);
        reset = 1'b1;
        spi_busy = 1'b1;
        sb.delete();
        repeat (3) @(negedge clk_150MHz_i);
        reset = 1'b0;
        spi_busy = 1'b0;
        @(negedge clk_150MHz_i);
    endtask

    task automatic wait_drained(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk_150MHz_i);
            i++;
        end
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain_timeout got %0d pending bytes expected 0", sb.size());
        end
        repeat (40) @(negedge clk_150MHz_i);
    endtask

    task automatic test_reset();
        uart_mode = 0;
        reset = 1'b1;
        spi_busy = 1'b1;
        repeat (3) @(negedge clk_150MHz_i);
        checks = checks + 4;
        if (tx_uart_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b expected 0", tx_uart_start); end
        if (tx_uart_data !== 8'h00) begin errors++; $display("FAIL rst_data got %02h expected 00", tx_uart_data); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d expected 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b expected 0", overflow); end
        reset = 1'b0;
        spi_busy = 1'b0;
        repeat (6) @(negedge clk_150MHz_i);
        checks = checks + 2;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_false_capture got level %0d expected 0", fifo_level); end
        if (n_starts != 0) begin errors++; $display("FAIL rst_no_start got %0d starts expected 0", n_starts); end
    endtask

    task automatic test_single_word();
        int s0 = n_starts;
        int n = 0;
        bit found = 0;
        uart_mode = 0;
        @(negedge clk_150MHz_i);
        spi_rx_data = 16'h1234;
        spi_busy = 1'b1;
        @(negedge clk_150MHz_i);
        spi_busy = 1'b0;
        push_word(16'h1234);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_150MHz_i);
            n++;
            if (tx_uart_start) found = 1;
        end
        checks = checks + 1;
        if (!found || n != 3) begin errors++; $display("FAIL latency got %0d cycles (found=%0d) expected 3", n, found); end
        wait_drained(200);
        checks = checks + 2;
        if (n_starts - s0 != c_BPW) begin errors++; $display("FAIL single_starts got %0d expected %0d", n_starts - s0, c_BPW); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level got %0d expected 0", fifo_level); end
    endtask

    task automatic test_header();
        int s0 = n_starts;
        uart_mode = 0;
        capture(16'hBEEF, 1);
        wait_drained(200);
        checks = checks + 1;
        if (n_starts - s0 != c_BPW) begin errors++; $display("FAIL header_starts got %0d expected %0d", n_starts - s0, c_BPW); end
    endtask

    task automatic test_overflow();
        int s0 = n_starts;
        uart_mode = 1;
        repeat (2) @(negedge clk_150MHz_i);
        for (int i = 1; i <= 6; i++) capture(16'(i), i <= 4);
        @(negedge clk_150MHz_i);
        checks = checks + 2;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d expected 4", fifo_level); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", overflow); end
        uart_mode = 0;
        wait_drained(600);
        checks = checks + 3;
        if (n_starts - s0 != 4 * c_BPW) begin errors++; $display("FAIL ovf_starts got %0d expected %0d", n_starts - s0, 4 * c_BPW); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drained_level got %0d expected 0", fifo_level); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        apply_reset();
        uart_mode = 1;
        repeat (2) @(negedge clk_150MHz_i);
        for (int i = 1; i <= 4; i++) capture(16'hA000 + 16'(i), 1);
        @(negedge clk_150MHz_i);
        spi_busy = 1'b1;
        spi_rx_data = 16'hA005;
        @(negedge clk_150MHz_i);
        // Capture and the first IDLE pop land on the same edge.
        spi_busy = 1'b0;
        uart_mode = 0;
        tx_uart_busy = 1'b0;
        push_word(16'hA005);
        @(negedge clk_150MHz_i);
        checks = checks + 2;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL pushpop_level got %0d expected 4", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow got %b expected 0", overflow); end
        wait_drained(800);
        checks = checks + 2;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL pushpop_drained got %0d expected 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_ovf_end got %b expected 0", overflow); end
    endtask

    task automatic test_ack_timeout();
        int t0 = 0;
        int t1 = 0;
        bit found = 0;
        apply_reset();
        uart_mode = 2;
        capture(16'h5AC3, 1);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_150MHz_i);
            if (tx_uart_start) begin found = 1; t0 = cyc; end
        end
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk_150MHz_i);
            if (tx_uart_start) begin found = 1; t1 = cyc; end
        end
        checks = checks + 1;
        if (!found || (t1 - t0) != c_ACK_GAP) begin
            errors++;
            $display("FAIL ack_timeout_gap got %0d cycles (found=%0d) expected %0d", t1 - t0, found, c_ACK_GAP);
        end
        wait_drained(200);
        checks = checks + 1;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL ack_timeout_level got %0d expected 0", fifo_level); end
        uart_mode = 0;
    endtask

    task automatic test_reset_mid();
        int s0 = 0;
        bit found = 0;
        apply_reset();
        uart_mode = 1;
        repeat (2) @(negedge clk_150MHz_i);
        for (int i = 0; i < 3; i++) capture(16'hC100 + 16'(i), 1);
        @(negedge clk_150MHz_i);
        uart_mode = 0;
        tx_uart_busy = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_150MHz_i);
            if (tx_uart_start) found = 1;
        end
        checks = checks + 1;
        if (!found || fifo_level !== 3'd2) begin errors++; $display("FAIL mid_queued got level %0d (found=%0d) expected 2", fifo_level, found); end
        repeat (2) @(negedge clk_150MHz_i);
        reset = 1'b1;
        sb.delete();
        @(negedge clk_150MHz_i);
        checks = checks + 4;
        if (tx_uart_start !== 1'b0) begin errors++; $display("FAIL mid_start got %b expected 0", tx_uart_start); end
        if (tx_uart_data !== 8'h00) begin errors++; $display("FAIL mid_data got %02h expected 00", tx_uart_data); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d expected 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b expected 0", overflow); end
        reset = 1'b0;
        s0 = n_starts;
        repeat (40) @(negedge clk_150MHz_i);
        checks = checks + 1;
        if (n_starts != s0) begin errors++; $display("FAIL mid_quiet got %0d starts expected 0", n_starts - s0); end
        capture(16'h7E81, 1);
        wait_drained(200);
        checks = checks + 1;
        if (n_starts - s0 != c_BPW) begin errors++; $display("FAIL mid_restart got %0d starts expected %0d", n_starts - s0, c_BPW); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_header();
        test_overflow();
        test_push_pop_full();
        test_ack_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
